// File: rtl/lc3_pkg.sv
// lc3_pkg: shared microstate constants and memory handshake state encoding
package lc3_pkg;
   localparam logic [5:0] FETCH_STATE = 6'd18;
   localparam logic [5:0] INT_STATE   = 6'd49;
   typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DONE} mem_st_t;
endpackage

// File: rtl/lc3_ustate_ctrl_if.sv
// lc3_ustate_ctrl_if: sequencer control, memory handshake and interrupt signals
interface lc3_ustate_ctrl_if;
   logic       run;
   logic       step;
   logic [5:0] Addr_next_state;
   logic       MIO_EN;
   logic       R_W;
   logic       mem_ack;
   logic       INT_req;
   logic [5:0] state;
   logic       R;
   logic       INT;
   logic       mem_req;
   logic       mem_we;
   logic       mem_err;
   modport master (output run, step, Addr_next_state, MIO_EN, R_W, mem_ack, INT_req,
                   input state, R, INT, mem_req, mem_we, mem_err);
   modport slave  (input run, step, Addr_next_state, MIO_EN, R_W, mem_ack, INT_req,
                   output state, R, INT, mem_req, mem_we, mem_err);
endinterface

// File: rtl/lc3_mem_handshake.sv
// lc3_mem_handshake: memory access FSM with bounded wait and sticky timeout error
module lc3_mem_handshake
   import lc3_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic mio_en,
   input  logic r_w,
   input  logic mem_ack,
   input  logic advance,
   output logic r,
   output logic mem_req,
   output logic mem_we,
   output logic mem_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   mem_st_t m, m_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic we_nxt, err_nxt;
   // mem_req is a decode of the state register, so reset drops it at once
   assign mem_req = m == M_WAIT;
   assign r = m == M_DONE;
   // handshake registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         m <= M_IDLE;
         cnt <= '0;
         mem_we <= 1'b0;
         mem_err <= 1'b0;
      end else begin
         m <= m_nxt;
         cnt <= cnt_nxt;
         mem_we <= we_nxt;
         mem_err <= err_nxt;
      end
   // next state; an ack on the timeout cycle wins over the timeout
   always_comb begin
      m_nxt = m;
      cnt_nxt = cnt;
      we_nxt = mem_we;
      err_nxt = mem_err;
      case (m)
         M_IDLE: if (mio_en) begin
            m_nxt = M_WAIT;
            cnt_nxt = '0;
            we_nxt = r_w;
         end
         M_WAIT: begin
            cnt_nxt = cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1;
            if (mem_ack) m_nxt = M_DONE;
            else if (cnt == CW'(TIMEOUT - 1)) begin
               m_nxt = M_DONE;
               err_nxt = 1'b1;
            end
         end
         M_DONE: if (advance) m_nxt = M_IDLE;
         default: m_nxt = M_IDLE;
      endcase
   end
endmodule

// File: rtl/lc3_ustate_ctrl.sv
// lc3_ustate_ctrl: microstate register, run/step control and interrupt latch
module lc3_ustate_ctrl #(
   parameter int         TIMEOUT     = 15,
   parameter logic [5:0] FETCH_STATE = lc3_pkg::FETCH_STATE,
   parameter logic [5:0] INT_STATE   = lc3_pkg::INT_STATE
) (
   input logic clk,
   input logic reset,
   lc3_ustate_ctrl_if.slave bus
);
   logic advance, int_prev;
   assign advance = bus.run | (~bus.run & bus.step);
   // microstate advances every cycle while running, once per step when halted
   always_ff @(posedge clk or posedge reset)
      if (reset) bus.state <= FETCH_STATE;
      else if (advance) bus.state <= bus.Addr_next_state;
   // rising edge of INT_req sets INT; leaving INT_STATE clears it, set wins
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         int_prev <= 1'b0;
         bus.INT <= 1'b0;
      end else begin
         int_prev <= bus.INT_req;
         bus.INT <= (bus.INT_req & ~int_prev) | (bus.INT & ~(bus.state == INT_STATE && advance));
      end
   lc3_mem_handshake #(.TIMEOUT(TIMEOUT)) u_mem (
      .clk(clk),
      .reset(reset),
      .mio_en(bus.MIO_EN),
      .r_w(bus.R_W),
      .mem_ack(bus.mem_ack),
      .advance(advance),
      .r(bus.R),
      .mem_req(bus.mem_req),
      .mem_we(bus.mem_we),
      .mem_err(bus.mem_err)
   );
endmodule

// File: tb/tb_lc3_ustate_ctrl.sv
// tb_lc3_ustate_ctrl: directed checks of sequencing, memory handshake and interrupt latch
module tb_lc3_ustate_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   lc3_ustate_ctrl_if bus();
   lc3_ustate_ctrl #(.TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      bus.run = 1'b1;
      bus.step = 1'b0;
      bus.Addr_next_state = 6'd33;
      bus.MIO_EN = 1'b0;
      bus.R_W = 1'b0;
      bus.mem_ack = 1'b0;
      bus.INT_req = 1'b0;
      tick();
      tick();
      chk("rst_state", 8'(bus.state), 8'd18);
      chk("rst_R", 8'(bus.R), 8'd0);
      chk("rst_INT", 8'(bus.INT), 8'd0);
      chk("rst_req", 8'(bus.mem_req), 8'd0);
      chk("rst_we", 8'(bus.mem_we), 8'd0);
      chk("rst_err", 8'(bus.mem_err), 8'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("first_adv", 8'(bus.state), 8'd33);
      // read, ack three cycles after mem_req rises
      bus.MIO_EN = 1'b1;
      tick();
      bus.MIO_EN = 1'b0;
      chk("rd_req", 8'(bus.mem_req), 8'd1);
      chk("rd_we", 8'(bus.mem_we), 8'd0);
      chk("rd_R_wait", 8'(bus.R), 8'd0);
      tick();
      chk("rd_req2", 8'(bus.mem_req), 8'd1);
      tick();
      chk("rd_req3", 8'(bus.mem_req), 8'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("rd_done_req", 8'(bus.mem_req), 8'd0);
      chk("rd_done_R", 8'(bus.R), 8'd1);
      chk("rd_err", 8'(bus.mem_err), 8'd0);
      tick();
      chk("rd_R_off", 8'(bus.R), 8'd0);
      // write, mem_we holds after R_W changes
      bus.MIO_EN = 1'b1;
      bus.R_W = 1'b1;
      tick();
      bus.MIO_EN = 1'b0;
      bus.R_W = 1'b0;
      chk("wr_we", 8'(bus.mem_we), 8'd1);
      tick();
      chk("wr_we_hold", 8'(bus.mem_we), 8'd1);
      chk("wr_req_hold", 8'(bus.mem_req), 8'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("wr_R", 8'(bus.R), 8'd1);
      tick();
      // ack coincides with the timeout cycle: acked, no error
      bus.MIO_EN = 1'b1;
      tick();
      bus.MIO_EN = 1'b0;
      for (int i = 1; i <= 14; i++) tick();
      chk("edge_req15", 8'(bus.mem_req), 8'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("edge_R", 8'(bus.R), 8'd1);
      chk("edge_err", 8'(bus.mem_err), 8'd0);
      tick();
      // no ack: timeout after 15 request cycles
      bus.MIO_EN = 1'b1;
      tick();
      bus.MIO_EN = 1'b0;
      for (int i = 1; i <= 14; i++) tick();
      chk("to_req15", 8'(bus.mem_req), 8'd1);
      tick();
      chk("to_req_off", 8'(bus.mem_req), 8'd0);
      chk("to_R", 8'(bus.R), 8'd1);
      chk("to_err", 8'(bus.mem_err), 8'd1);
      tick();
      chk("to_err_sticky", 8'(bus.mem_err), 8'd1);
      // interrupt set, then cleared by advancing out of state 49
      bus.Addr_next_state = 6'd32;
      tick();
      chk("int_st32", 8'(bus.state), 8'd32);
      bus.INT_req = 1'b1;
      tick();
      bus.INT_req = 1'b0;
      chk("int_set", 8'(bus.INT), 8'd1);
      bus.Addr_next_state = 6'd49;
      tick();
      chk("int_st49", 8'(bus.INT), 8'd1);
      bus.Addr_next_state = 6'd0;
      tick();
      chk("int_clr", 8'(bus.INT), 8'd0);
      // new edge in the clearing cycle keeps INT set
      bus.Addr_next_state = 6'd32;
      tick();
      bus.INT_req = 1'b1;
      tick();
      bus.INT_req = 1'b0;
      bus.Addr_next_state = 6'd49;
      tick();
      bus.INT_req = 1'b1;
      bus.Addr_next_state = 6'd0;
      tick();
      bus.INT_req = 1'b0;
      chk("int_setwins", 8'(bus.INT), 8'd1);
      chk("int_state0", 8'(bus.state), 8'd0);
      // halted access parks in M_DONE until a step
      bus.run = 1'b0;
      bus.Addr_next_state = 6'd5;
      bus.MIO_EN = 1'b1;
      tick();
      bus.MIO_EN = 1'b0;
      chk("halt_req", 8'(bus.mem_req), 8'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      tick();
      chk("halt_R", 8'(bus.R), 8'd1);
      chk("halt_state", 8'(bus.state), 8'd0);
      bus.MIO_EN = 1'b1;
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      chk("step_state", 8'(bus.state), 8'd5);
      chk("step_R", 8'(bus.R), 8'd0);
      chk("step_req_blk", 8'(bus.mem_req), 8'd0);
      tick();
      bus.MIO_EN = 1'b0;
      chk("step_req_new", 8'(bus.mem_req), 8'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      bus.run = 1'b1;
      tick();
      // reset in the middle of a wait
      bus.Addr_next_state = 6'd7;
      bus.MIO_EN = 1'b1;
      tick();
      bus.MIO_EN = 1'b0;
      tick();
      chk("mid_req", 8'(bus.mem_req), 8'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_req", 8'(bus.mem_req), 8'd0);
      chk("async_state", 8'(bus.state), 8'd18);
      chk("async_err", 8'(bus.mem_err), 8'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("post_R1", 8'(bus.R), 8'd0);
      chk("post_state", 8'(bus.state), 8'd7);
      tick();
      chk("post_R2", 8'(bus.R), 8'd0);
      chk("post_req", 8'(bus.mem_req), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/lc3_ustate_ctrl.md
LC3_USTATE_CTRL -- requirements
Module: lc3_ustate_ctrl

Interface
- REQ-001: Parameter TIMEOUT, default 15; maximum number of cycles spent waiting for mem_ack before the access is forced complete.
- REQ-002: Parameter FETCH_STATE, default 6'd18; microstate loaded at reset.
- REQ-003: Parameter INT_STATE, default 6'd49; microstate that services an interrupt.
- REQ-004: clk  in  1  single clock; all registers update on its rising edge.
- REQ-005: reset  in  1  asynchronous, active-high reset.
- REQ-006: run  in  1  1 = advance the microstate every cycle; 0 = halted.
- REQ-007: step  in  1  single-cycle pulse; while halted, advances the microstate once.
- REQ-008: Addr_next_state  in  6  next microstate computed by the microsequencer.
- REQ-009: MIO_EN  in  1  control-word bit; the current microstate performs a memory access.
- REQ-010: R_W  in  1  control-word bit; 1 = write, 0 = read.
- REQ-011: mem_ack  in  1  memory completion strobe.
- REQ-012: INT_req  in  1  external interrupt request level.
- REQ-013: state  out  6  current microstate; addresses the control store.
- REQ-014: R  out  1  memory-ready flag to the microsequencer.
- REQ-015: INT  out  1  pending-interrupt flag to the microsequencer.
- REQ-016: mem_req  out  1  memory request strobe.
- REQ-017: mem_we  out  1  write enable; valid while mem_req=1.
- REQ-018: mem_err  out  1  sticky flag; set when an access times out.

Function
- REQ-019: advance = run | (~run & step); when advance=1, state SHALL load Addr_next_state; otherwise state SHALL hold.
- REQ-020: The memory FSM SHALL have three states: M_IDLE, M_WAIT and M_DONE.
- REQ-021: M_IDLE -> M_WAIT when MIO_EN=1; on entry, mem_req goes to 1 and mem_we is set to R_W. Both are registered, so they rise 1 cycle after MIO_EN is seen.
- REQ-022: In M_WAIT, mem_req and mem_we SHALL hold. mem_ack=1 -> M_DONE.
- REQ-023: In M_WAIT, a wait counter increments each cycle. If it reaches TIMEOUT with no ack -> M_DONE and mem_err is set.
- REQ-024: If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the access SHALL be treated as acked and mem_err SHALL NOT be set.
- REQ-025: In M_DONE, R=1 and mem_req=0. The FSM stays in M_DONE until advance=1, then -> M_IDLE. R is 0 in all other states.
- REQ-026: A new access cannot start in the M_DONE exit cycle. The earliest new mem_req SHALL be 2 cycles after leaving M_DONE.
- REQ-027: INT SHALL set on a rising edge of INT_req, detected with a 1-cycle registered previous sample.
- REQ-028: INT SHALL clear when state==INT_STATE and advance=1.
- REQ-029: If an INT set and an INT clear occur in the same cycle, the set SHALL win.
- REQ-030: The wait counter SHALL be sized as clog2(TIMEOUT+1) bits, SHALL clear on entering M_WAIT, and SHALL saturate.
- REQ-031: Halting (run=0) SHALL NOT abort an access in progress; M_WAIT continues, and the FSM parks in M_DONE with R=1.

Reset
- REQ-032: When reset is asserted, state SHALL be FETCH_STATE, the memory FSM SHALL be M_IDLE, and R, INT, mem_req, mem_we and mem_err SHALL all be 0.
- REQ-033: The wait counter and the INT_req edge register SHALL clear to 0 on reset.
- REQ-034: Reset asserted during M_WAIT SHALL drop mem_req immediately (asynchronously); no R pulse SHALL follow.
- REQ-035: mem_err SHALL clear only on reset.

Structure
- REQ-036: The shared package lc3_pkg SHALL hold FETCH_STATE, INT_STATE and the M_IDLE/M_WAIT/M_DONE encoding.
- REQ-037: The memory FSM and its wait counter SHALL be the single sub-module lc3_mem_handshake. The top level holds the microstate register and the interrupt latch.

Verification
- REQ-038: Reset release, run=1, Addr_next_state=6'd33 -> state=18 during reset, then 33 on the first edge after release.
- REQ-039: MIO_EN=1, R_W=0, mem_ack 3 cycles after mem_req rises -> mem_req high 3 cycles, then R=1 for 1 cycle, mem_we=0, mem_err=0.
- REQ-040: MIO_EN=1, mem_ack never asserted, TIMEOUT=15 -> mem_req high 15 cycles, then R=1 and mem_err=1 (sticky until reset).
- REQ-041: Pulse INT_req while state=32; advance state to 49 -> INT=1 from the cycle after the edge, cleared after the state-49 advance. Repeat with a new INT_req edge in that same cycle -> INT stays 1.
- REQ-042: run=0 with an access completing -> R stays 1 and state holds. A step pulse -> state loads Addr_next_state, R=0 next cycle, and mem_req cannot reassert for 2 cycles.
- REQ-043: Assert reset mid-M_WAIT -> mem_req=0 asynchronously, state=18, and no R pulse after release.
